// File: rtl/seg_shift_driver_pkg.sv
// Shared definitions for the serial 7-segment driver.
//   seg_state_t : frame sequencer states (2-bit encoding)
//   SEG_NBITS   : bits per frame (8 digits x 8 segments incl. DP)
//   SEG_BLANK   : all segments off (the image is active-low)
package seg_shift_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } seg_state_t;

  localparam int          SEG_NBITS = 64;
  localparam logic [63:0] SEG_BLANK = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/seg_bit_timer.sv
// Half-period timer for the serial clock.
// Counts 0..CLK_DIV-1 while enabled and asserts tick on the last count.
// The counter wraps on tick and is held at zero while disabled, so every
// enable window starts with a full half period.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : count enable (frame in progress)
//   tick : high in the last cycle of each half period
module seg_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = en && (div_cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_shift_driver.sv
// Serialises a 64-bit active-low segment image onto a shift-register
// 7-segment interface, MSB first, followed by a storage latch pulse.
//   clk       : system clock
//   rst       : synchronous active-high reset (aborts a frame at once)
//   digits    : segment image, snapshotted when a frame is accepted
//   start     : frame request, accepted only in IDLE
//   busy      : frame in progress
//   done      : one-cycle pulse after the latch pulse
//   seg_sclk  : serial clock, data valid on its rising edge
//   seg_sdo   : serial data
//   seg_latch : storage register latch, high for CLK_DIV cycles
//   seg_clrn  : shift register clear, low only while in reset
//
// state    | meaning
// ST_IDLE  | waiting for start; done pulses here for one cycle
// ST_SHIFT | clocking out 64 bits, 2*CLK_DIV cycles each
// ST_LATCH | latch high for CLK_DIV cycles
module seg_shift_driver
  import seg_shift_driver_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int NBITS   = SEG_NBITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] digits,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        seg_sclk,
  output logic        seg_sdo,
  output logic        seg_latch,
  output logic        seg_clrn
);

  localparam logic [5:0] LAST_BIT = 6'(NBITS - 1);

  seg_state_t          state, state_n;
  logic [SEG_NBITS-1:0] shreg, shreg_n;
  logic [5:0]          bit_cnt, bit_cnt_n;
  logic                busy_n, done_n, sclk_n, sdo_n, latch_n;
  logic                tick;

  // The timer runs through both SHIFT and LATCH; the final SHIFT tick wraps
  // it to zero, so LATCH gets exactly CLK_DIV cycles from the same counter.
  seg_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   ((state == ST_SHIFT) || (state == ST_LATCH)),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_sclk  <= 1'b0;
      seg_sdo   <= 1'b1;
      seg_latch <= 1'b0;
      seg_clrn  <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      seg_sclk  <= sclk_n;
      seg_sdo   <= sdo_n;
      seg_latch <= latch_n;
      seg_clrn  <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    busy_n    = busy;
    done_n    = 1'b0;
    sclk_n    = seg_sclk;
    sdo_n     = seg_sdo;
    latch_n   = seg_latch;

    case (state)
      ST_IDLE: begin
        busy_n  = 1'b0;
        sclk_n  = 1'b0;
        latch_n = 1'b0;
        if (start) begin
          state_n   = ST_SHIFT;
          shreg_n   = digits;
          bit_cnt_n = '0;
          sdo_n     = digits[SEG_NBITS-1];
          busy_n    = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (!seg_sclk) begin
            sclk_n = 1'b1;
          end else begin
            // Falling serial clock ends the bit; next data bit presented here
            // so it is stable for the whole following low/high period.
            sclk_n = 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state_n = ST_LATCH;
              latch_n = 1'b1;
            end else begin
              shreg_n   = {shreg[SEG_NBITS-2:0], 1'b0};
              bit_cnt_n = bit_cnt + 6'd1;
              sdo_n     = shreg[SEG_NBITS-2];
            end
          end
        end
      end

      ST_LATCH: begin
        sclk_n = 1'b0;
        if (tick) begin
          state_n = ST_IDLE;
          latch_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule
